rs_age_issue_scheduler: RTL and testbench
=========================================

Name: rs_age_issue_scheduler

Overview:
- Sequential issue scheduler for the ALU reservation stations.
- Tracks the allocation order of RS entries in an age matrix and owns per-FU busy counters for multi-cycle ops.
- Each cycle it dispatches up to NUM_OF_FU of the oldest ready entries onto free ALUs.
- Sits between the RS entry array (alloc/ready) and the ALU cluster. It replaces the purely combinational index-priority RS-to-FU pairing with oldest-first, latency-aware issue.

Parameters:
- NUM_OF_RS, default `RS_ALU_ENTRIES_NUM` (8): number of RS entries.
- NUM_OF_FU, default `NUM_OF_ALUS` (2): number of ALUs.
- LAT_WIDTH, default 3: width of the per-entry op latency field.
- FU_IDX_WIDTH, default (NUM_OF_FU<=1)?1:$clog2(NUM_OF_FU): FU index width. Derived; do not override.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- alloc_en  in  NUM_OF_RS  entries written by rename/dispatch this cycle
- flush  in  1  pipeline flush; kills all RS entries
- rs_ready  in  NUM_OF_RS  entry operands ready
- issue_lat  in  LAT_WIDTH x NUM_OF_RS  per-entry execute latency in cycles
- rs_dispatch_en  out  NUM_OF_RS  entry issues this cycle
- rs_fu_assign  out  FU_IDX_WIDTH x NUM_OF_RS  target ALU of each issuing entry
- fu_busy  out  NUM_OF_FU  ALU occupied by a multi-cycle op

Behaviour:
- State:
  - valid[NUM_OF_RS]
  - age matrix older[i][j], where 1 means i is older than j
  - busy_cnt[NUM_OF_FU], each LAT_WIDTH wide
- Reset (async):
  - valid, older and busy_cnt are all cleared.
  - While reset is high, rs_dispatch_en=0, rs_fu_assign=0 and fu_busy=0.
- Eligibility: entry i is eligible when valid[i] & rs_ready[i]. Ready on an invalid entry is ignored.
- FU k is free when busy_cnt[k]==0. fu_busy[k] = (busy_cnt[k]!=0).
- Selection is combinational on the current state and inputs (zero-cycle issue):
  - Round r (r=0..NUM_OF_FU-1) picks the oldest eligible entry not yet picked.
  - That entry goes to the r-th lowest-index free FU.
  - Rounds stop when entries or free FUs run out.
  - Unassigned entries have rs_fu_assign=0 and rs_dispatch_en=0.
- Oldest: entry i with no eligible j such that older[j][i].
- Clock edge:
  - A dispatched entry clears valid.
  - An FU receiving an op with issue_lat L>=2 loads busy_cnt=L-1.
  - For L of 0 or 1 the FU is pipelined and stays free.
  - A nonzero busy_cnt decrements by 1 each cycle.
- Allocation of entry i:
  - Sets valid[i], clears row i, and sets column i for every other valid or simultaneously allocated older entry.
  - The new entry is therefore youngest.
  - Simultaneous allocs: a lower index is older.
- Same-cycle dispatch and alloc of the same entry: alloc wins. The entry stays valid and becomes youngest.
- alloc_en on an already-valid, non-dispatching entry is illegal. The RTL keeps the old entry and fires an assertion.
- flush: clears valid and the age matrix next edge. allocs in the same cycle are dropped. Dispatch that cycle still occurs. busy_cnt keeps draining, because in-flight ops complete.
- All FUs busy or no eligible entries: no dispatch, state holds except counter decrement.

Optional Feature:
- Macro: RS_SCHED_STATS_EN.
- With the macro defined, adds two outputs, each a 32-bit counter:
  - stat_dispatch_cnt: increments by the popcount of rs_dispatch_en each cycle.
  - stat_stall_cnt: increments by 1 in any cycle where some entry is eligible but not dispatched.
- Both counters wrap and are cleared by reset, not by flush.
- Without the macro: no ports, no counters; the behaviour is otherwise identical.

Decomposition:
- Package rs_sched_pkg holds:
  - the FU_IDX_WIDTH helper function
  - the typedef lat_t (logic [LAT_WIDTH-1:0])
  - the age-matrix row typedef
- Sub-module rs_age_matrix: owns valid/older, alloc/flush/dealloc updates and an oldest-of-mask query. The scheduler instantiates it and performs the NUM_OF_FU selection rounds.

Test Plan:
- Order beats index: alloc entry 3, then entry 0 a cycle later; ready both, 1 FU free -> entry 3 dispatches to FU0, then entry 0 the next cycle.
- Two FUs, two picks: allocs 5,2,7 in that order; ready all -> rs_dispatch_en[5]=1 with assign 0 and [2]=1 with assign 1; entry 7 next cycle.
- Multi-cycle op: entry 1 with issue_lat=3 to FU0 -> fu_busy[0]=1 for 2 cycles; ready entries during that window go only to FU1.
- Simultaneous alloc of 4 and 6, plus same-cycle re-alloc of dispatching entry 4 -> 4 is youngest and still valid.
- Flush with alloc_en[2]=1 and an op in flight on FU1 -> valid all 0 next cycle, entry 2 not allocated, fu_busy[1] keeps counting down.
- Async reset mid-operation, asserted between edges -> outputs drop to 0 immediately; after release no dispatch until new allocs. With RS_SCHED_STATS_EN, counters read 0.

Source files
------------

// File: rtl/rs_sched_pkg.sv
// Shared types and helpers for the RS age-ordered issue scheduler.
// Default geometry comes from RS_ALU_ENTRIES_NUM / NUM_OF_ALUS when the build does not define them.
`ifndef RS_ALU_ENTRIES_NUM
`define RS_ALU_ENTRIES_NUM 8
`endif
`ifndef NUM_OF_ALUS
`define NUM_OF_ALUS 2
`endif

package rs_sched_pkg;
  localparam int RS_DEF    = `RS_ALU_ENTRIES_NUM;
  localparam int FU_DEF    = `NUM_OF_ALUS;
  localparam int LAT_W_DEF = 3;

  typedef logic [LAT_W_DEF-1:0] lat_t;
  typedef logic [RS_DEF-1:0]    age_row_t;

  function automatic int fu_idx_width(input int num_fu);
    return (num_fu <= 1) ? 1 : $clog2(num_fu);
  endfunction
endpackage

// File: rtl/rs_age_matrix.sv
// Age matrix for RS entries: valid bits, pairwise older[i][j] and an age-rank query.
// rank[i] counts masked entries older than i; rank==0 marks the oldest of the mask.
import rs_sched_pkg::*;

module rs_age_matrix #(
  parameter int NUM_OF_RS = RS_DEF,
  parameter int RANK_W    = $clog2(NUM_OF_RS + 1)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_OF_RS-1:0]             alloc_en,
  input  logic                             flush,
  input  logic [NUM_OF_RS-1:0]             dealloc,
  input  logic [NUM_OF_RS-1:0]             query_mask,
  output logic [NUM_OF_RS-1:0]             valid,
  output logic [NUM_OF_RS-1:0][RANK_W-1:0] rank
);
  logic [NUM_OF_RS-1:0]                valid_r;
  logic [NUM_OF_RS-1:0][NUM_OF_RS-1:0] older_r;
  logic [NUM_OF_RS-1:0][NUM_OF_RS-1:0] older_nxt_s;
  logic [NUM_OF_RS-1:0]                alloc_s;

  // An alloc onto a live entry that is not leaving this cycle is dropped; the old entry survives.
  assign alloc_s = alloc_en & ~(valid_r & ~dealloc);
  assign valid   = valid_r;

  // Next matrix: a new entry's row is cleared, its column marks every entry older than it.
  always_comb begin
    for (int i = 0; i < NUM_OF_RS; i++) begin
      older_nxt_s[i] = alloc_s[i] ? '0 : older_r[i];
    end
    for (int i = 0; i < NUM_OF_RS; i++) begin
      for (int j = 0; j < NUM_OF_RS; j++) begin
        older_nxt_s[j][i] = alloc_s[i] ? ((j != i) && (alloc_s[j] ? (j < i) : valid_r[j]))
                                       : older_nxt_s[j][i];
      end
    end
  end

  // Age rank of each entry within the query mask.
  always_comb begin
    for (int i = 0; i < NUM_OF_RS; i++) begin
      rank[i] = '0;
      for (int j = 0; j < NUM_OF_RS; j++) begin
        rank[i] = rank[i] + RANK_W'(query_mask[j] & older_r[j][i]);
      end
    end
  end

  // Entry state; flush wipes everything including same-cycle allocs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r <= '0;
      older_r <= '0;
    end else if (flush) begin
      valid_r <= '0;
      older_r <= '0;
    end else begin
      valid_r <= (valid_r & ~dealloc) | alloc_s;
      older_r <= older_nxt_s;
    end
  end
endmodule

// File: rtl/rs_age_matrix_chk.sv
// Protocol checker: alloc_en must not target a valid entry that is not dispatching.
module rs_age_matrix_chk #(
  parameter int NUM_OF_RS = 8
) (
  input logic                 clk,
  input logic                 reset,
  input logic [NUM_OF_RS-1:0] alloc_en,
  input logic [NUM_OF_RS-1:0] valid,
  input logic [NUM_OF_RS-1:0] dealloc
);
  a_no_alloc_on_live: assert property (@(posedge clk) disable iff (reset)
    (alloc_en & valid & ~dealloc) == '0);
endmodule

// File: rtl/rs_age_issue_scheduler.sv
// Oldest-first, latency-aware issue from the ALU reservation stations onto the ALU cluster.
// Optional macro RS_SCHED_STATS_EN adds dispatch/stall statistics counters.
import rs_sched_pkg::*;

module rs_age_issue_scheduler #(
  parameter int NUM_OF_RS    = RS_DEF,
  parameter int NUM_OF_FU    = FU_DEF,
  parameter int LAT_WIDTH    = LAT_W_DEF,
  parameter int FU_IDX_WIDTH = fu_idx_width(NUM_OF_FU)
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_OF_RS-1:0]                   alloc_en,
  input  logic                                   flush,
  input  logic [NUM_OF_RS-1:0]                   rs_ready,
  input  logic [NUM_OF_RS-1:0][LAT_WIDTH-1:0]    issue_lat,
  output logic [NUM_OF_RS-1:0]                   rs_dispatch_en,
  output logic [NUM_OF_RS-1:0][FU_IDX_WIDTH-1:0] rs_fu_assign,
  output logic [NUM_OF_FU-1:0]                   fu_busy
`ifdef RS_SCHED_STATS_EN
  ,
  output logic [31:0]                            stat_dispatch_cnt,
  output logic [31:0]                            stat_stall_cnt
`endif
);
  localparam int RANK_W  = $clog2(NUM_OF_RS + 1);
  localparam int FRANK_W = $clog2(NUM_OF_FU + 1);

  logic [NUM_OF_RS-1:0]                   valid_s;
  logic [NUM_OF_RS-1:0]                   elig_s;
  logic [NUM_OF_RS-1:0]                   dispatch_s;
  logic [NUM_OF_RS-1:0][RANK_W-1:0]       rank_s;
  logic [NUM_OF_RS-1:0][FU_IDX_WIDTH-1:0] assign_s;
  logic [NUM_OF_FU-1:0][LAT_WIDTH-1:0]    busy_cnt_r;
  logic [NUM_OF_FU-1:0]                   free_s;
  logic [NUM_OF_FU-1:0][FRANK_W-1:0]      free_rank_s;
  logic [FRANK_W-1:0]                     nfree_s;
  logic [NUM_OF_FU-1:0]                   fu_load_s;
  logic [NUM_OF_FU-1:0][LAT_WIDTH-1:0]    fu_lat_s;

  assign elig_s = valid_s & rs_ready;

  rs_age_matrix #(.NUM_OF_RS(NUM_OF_RS), .RANK_W(RANK_W)) u_age (
    .clk        (clk),
    .reset      (reset),
    .alloc_en   (alloc_en),
    .flush      (flush),
    .dealloc    (dispatch_s),
    .query_mask (elig_s),
    .valid      (valid_s),
    .rank       (rank_s)
  );

  rs_age_matrix_chk #(.NUM_OF_RS(NUM_OF_RS)) u_age_chk (
    .clk      (clk),
    .reset    (reset),
    .alloc_en (alloc_en),
    .valid    (valid_s),
    .dealloc  (dispatch_s)
  );

  // Free FUs are handed out in index order: free_rank is the slot position among free FUs.
  always_comb begin
    nfree_s = '0;
    for (int k = 0; k < NUM_OF_FU; k++) begin
      free_s[k]      = (busy_cnt_r[k] == '0);
      free_rank_s[k] = nfree_s;
      nfree_s        = nfree_s + FRANK_W'(free_s[k]);
    end
  end

  // Round r of oldest-first selection is the eligible entry with age rank r.
  always_comb begin
    dispatch_s = '0;
    assign_s   = '0;
    fu_load_s  = '0;
    fu_lat_s   = '0;
    for (int i = 0; i < NUM_OF_RS; i++) begin
      if (elig_s[i] && (int'(rank_s[i]) < NUM_OF_FU) && (int'(rank_s[i]) < int'(nfree_s))) begin
        dispatch_s[i] = 1'b1;
        for (int k = 0; k < NUM_OF_FU; k++) begin
          if (free_s[k] && (int'(free_rank_s[k]) == int'(rank_s[i]))) begin
            assign_s[i]  = FU_IDX_WIDTH'(k);
            fu_load_s[k] = 1'b1;
            fu_lat_s[k]  = issue_lat[i];
          end else begin
            fu_load_s[k] = fu_load_s[k];
          end
        end
      end else begin
        dispatch_s[i] = 1'b0;
      end
    end
  end

  // Output drive, forced quiet while reset is held.
  always_comb begin
    if (reset) begin
      rs_dispatch_en = '0;
      rs_fu_assign   = '0;
      fu_busy        = '0;
    end else begin
      rs_dispatch_en = dispatch_s;
      rs_fu_assign   = assign_s;
      fu_busy        = ~free_s;
    end
  end

  // Multi-cycle ops hold their FU for L-1 further cycles; in-flight ops drain across flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_cnt_r <= '0;
    end else begin
      for (int k = 0; k < NUM_OF_FU; k++) begin
        if (fu_load_s[k] && (fu_lat_s[k] >= LAT_WIDTH'(2))) begin
          busy_cnt_r[k] <= fu_lat_s[k] - LAT_WIDTH'(1);
        end else if (busy_cnt_r[k] != '0) begin
          busy_cnt_r[k] <= busy_cnt_r[k] - LAT_WIDTH'(1);
        end else begin
          busy_cnt_r[k] <= busy_cnt_r[k];
        end
      end
    end
  end

`ifdef RS_SCHED_STATS_EN
  // Wrapping statistics; flush does not clear them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_dispatch_cnt <= 32'd0;
      stat_stall_cnt    <= 32'd0;
    end else begin
      stat_dispatch_cnt <= stat_dispatch_cnt + 32'($countones(dispatch_s));
      stat_stall_cnt    <= stat_stall_cnt + {31'd0, |(elig_s & ~dispatch_s)};
    end
  end
`endif
endmodule

// File: tb/tb_rs_age_issue_scheduler.sv
// Directed-vector bench for rs_age_issue_scheduler (8 RS entries, 2 ALUs, 3-bit latency).
module tb_rs_age_issue_scheduler;
  logic            clk = 1'b0;
  logic            reset;
  logic [7:0]      alloc_en;
  logic            flush;
  logic [7:0]      rs_ready;
  logic [7:0][2:0] issue_lat;
  logic [7:0]      rs_dispatch_en;
  logic [7:0]      rs_fu_assign;
  logic [1:0]      fu_busy;
`ifdef RS_SCHED_STATS_EN
  logic [31:0]     stat_dispatch_cnt;
  logic [31:0]     stat_stall_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rs_age_issue_scheduler dut (
    .clk            (clk),
    .reset          (reset),
    .alloc_en       (alloc_en),
    .flush          (flush),
    .rs_ready       (rs_ready),
    .issue_lat      (issue_lat),
    .rs_dispatch_en (rs_dispatch_en),
    .rs_fu_assign   (rs_fu_assign),
    .fu_busy        (fu_busy)
`ifdef RS_SCHED_STATS_EN
    ,
    .stat_dispatch_cnt (stat_dispatch_cnt),
    .stat_stall_cnt    (stat_stall_cnt)
`endif
  );

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [7:0] disp, input logic [7:0] asg,
                            input logic [1:0] busy);
    check_vec({tag, ".disp"}, 32'(rs_dispatch_en), 32'(disp));
    check_vec({tag, ".asg"},  32'(rs_fu_assign),   32'(asg));
    check_vec({tag, ".busy"}, 32'(fu_busy),        32'(busy));
  endtask

  task automatic clear_in();
    alloc_en  = 8'h00;
    flush     = 1'b0;
    rs_ready  = 8'h00;
    issue_lat = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clear_in();
  endtask

  initial begin
    reset = 1'b1;
    clear_in();
    rs_ready = 8'hFF;
    @(posedge clk);
    #1;
    expect_out("reset", 8'h00, 8'h00, 2'b00);
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_in();

    // Occupy FU1 with a 4-cycle op so only FU0 is free for the order test.
    alloc_en = 8'hC0;                                            #1; expect_out("c0", 8'h00, 8'h00, 2'b00);
    step(); alloc_en = 8'h08; rs_ready = 8'hC0;
    issue_lat[6] = 3'd1; issue_lat[7] = 3'd4;                    #1; expect_out("pair67", 8'hC0, 8'h80, 2'b00);
    step(); alloc_en = 8'h01;                                    #1; expect_out("alloc0", 8'h00, 8'h00, 2'b10);
    step(); rs_ready = 8'h09; issue_lat[0] = 3'd1; issue_lat[3] = 3'd1;
                                                                 #1; expect_out("order3", 8'h08, 8'h00, 2'b10);
    step(); rs_ready = 8'h01; issue_lat[0] = 3'd1;               #1; expect_out("order0", 8'h01, 8'h00, 2'b10);

    // Allocation order 5, 2, 7 then two picks.
    step(); alloc_en = 8'h20;                                    #1; expect_out("drain1", 8'h00, 8'h00, 2'b00);
    step(); alloc_en = 8'h04;
    step(); alloc_en = 8'h80;
    step(); rs_ready = 8'hA4;                                    #1; expect_out("two_pick", 8'h24, 8'h04, 2'b00);
    step(); rs_ready = 8'h80;                                    #1; expect_out("pick7", 8'h80, 8'h00, 2'b00);

    // Latency-3 op on FU0 keeps it busy for two cycles.
    step(); alloc_en = 8'h12;
    step(); rs_ready = 8'h02; issue_lat[1] = 3'd3;               #1; expect_out("mc_issue", 8'h02, 8'h00, 2'b00);
    step(); alloc_en = 8'h08; rs_ready = 8'h10; issue_lat[4] = 3'd1;
                                                                 #1; expect_out("mc_busy1", 8'h10, 8'h10, 2'b01);
    step(); rs_ready = 8'h08; issue_lat[3] = 3'd1;               #1; expect_out("mc_busy2", 8'h08, 8'h08, 2'b01);

    // Simultaneous alloc 4,6 then re-alloc of dispatching 4.
    step(); alloc_en = 8'h50;                                    #1; expect_out("mc_free", 8'h00, 8'h00, 2'b00);
    step(); alloc_en = 8'h10; rs_ready = 8'h10; issue_lat[4] = 3'd1;
                                                                 #1; expect_out("realloc4", 8'h10, 8'h00, 2'b00);
    step(); rs_ready = 8'h50; issue_lat[4] = 3'd1; issue_lat[6] = 3'd1;
                                                                 #1; expect_out("young4", 8'h50, 8'h10, 2'b00);

    // Flush with a same-cycle alloc and an op draining on FU1.
    step(); alloc_en = 8'h22;
    step(); alloc_en = 8'h01; rs_ready = 8'h22; issue_lat[1] = 3'd1; issue_lat[5] = 3'd4;
                                                                 #1; expect_out("pre_flush", 8'h22, 8'h20, 2'b00);
    step(); flush = 1'b1; alloc_en = 8'h04; rs_ready = 8'h01; issue_lat[0] = 3'd1;
                                                                 #1; expect_out("flush", 8'h01, 8'h00, 2'b10);
    step(); rs_ready = 8'hFF;                                    #1; expect_out("post_flush", 8'h00, 8'h00, 2'b10);
    step(); rs_ready = 8'hFF;                                    #1; expect_out("drain2", 8'h00, 8'h00, 2'b10);
    step(); alloc_en = 8'h0C;                                    #1; expect_out("drained", 8'h00, 8'h00, 2'b00);

    // Asynchronous reset asserted between clock edges.
    step(); rs_ready = 8'h0C; issue_lat[2] = 3'd7; issue_lat[3] = 3'd7;
                                                                 #1; expect_out("pre_rst", 8'h0C, 8'h08, 2'b00);
    reset = 1'b1;                                                #1; expect_out("async_rst", 8'h00, 8'h00, 2'b00);
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_in();
    rs_ready = 8'hFF;                                            #1; expect_out("post_rst", 8'h00, 8'h00, 2'b00);
`ifdef RS_SCHED_STATS_EN
    check_vec("stat_disp", stat_dispatch_cnt, 32'd0);
    check_vec("stat_stall", stat_stall_cnt, 32'd0);
`endif
    step(); alloc_en = 8'h02;
    step(); rs_ready = 8'h02;                                    #1; expect_out("revive", 8'h02, 8'h00, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
